// File: rtl/div3b_seq.sv
// Sequential restoring divider producing one quotient bit per clock under a start/done handshake.
// Define DIV3B_EARLY_EN to finish immediately when the divisor exceeds the dividend.
module div3b_seq #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] q,
  output logic [W-1:0] r,
  output logic         busy,
  output logic         done,
  output logic         div0
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   dvd_q, dvd_d;
  logic [W-1:0]   dvs_q, dvs_d;
  logic [W:0]     rem_q, rem_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           zero_q, zero_d;
  logic [W-1:0]   q_q, q_d;
  logic [W-1:0]   r_q, r_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           div0_q, div0_d;
  logic [W:0]     rem_shift;
  logic [W:0]     dvs_ext;

  // The dividend register doubles as the quotient register: each step shifts
  // the dividend MSB into the remainder and the new quotient bit into its LSB.
  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    zero_d    = zero_q;
    q_d       = q_q;
    r_d       = r_q;
    div0_d    = div0_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    dvs_ext   = {1'b0, dvs_q};
    rem_shift = (rem_q << 1) | {{W{1'b0}}, dvd_q[W-1]};

    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d   = x;
          dvs_d   = y;
          rem_d   = '0;
          cnt_d   = CW'(W - 1);
          zero_d  = 1'b0;
          state_d = CALC;
          if (y == '0) begin
            dvd_d   = '1;
            rem_d   = {1'b0, x};
            zero_d  = 1'b1;
            state_d = DONE;
          end
`ifdef DIV3B_EARLY_EN
          else if (y > x) begin
            dvd_d   = '0;
            rem_d   = {1'b0, x};
            state_d = DONE;
          end
`endif
        end
      end
      CALC: begin
        busy_d = 1'b1;
        if (rem_shift >= dvs_ext) begin
          rem_d = rem_shift - dvs_ext;
          dvd_d = {dvd_q[W-2:0], 1'b1};
        end else begin
          rem_d = rem_shift;
          dvd_d = {dvd_q[W-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        busy_d  = 1'b1;
        done_d  = 1'b1;
        q_d     = dvd_q;
        r_d     = rem_q[W-1:0];
        div0_d  = zero_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      q_q     <= q_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      div0_q  <= div0_d;
    end
  end

  assign q    = q_q;
  assign r    = r_q;
  assign busy = busy_q;
  assign done = done_q;
  assign div0 = div0_q;

endmodule
